// File: rtl/pwm_decoder_if.sv
// PWM decoder bus: the sampled PWM line in, decoded duty and frame status out.
interface pwm_decoder_if #(
  parameter int DUTY_W = 5
) ();
  logic              pwm_in;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              locked;
  logic              period_err;

  modport master (
    input  pwm_in,
    output duty,
    output duty_valid,
    output locked,
    output period_err
  );

  modport slave (
    output pwm_in,
    input  duty,
    input  duty_valid,
    input  locked,
    input  period_err
  );
endinterface

// File: rtl/pwm_decoder.sv
// Recovers the per-frame high-cycle count from a fixed-period PWM line that is
// asynchronous to clk_out, and tracks frame lock and malformed frames.
module pwm_decoder #(
  parameter int DUTY_W      = 5,
  parameter int LOW_TIMEOUT = 63
) (
  input  logic          clk_out,
  input  logic          reset,
  pwm_decoder_if.master bus
);

  localparam int               CNT_W  = DUTY_W + 1;
  localparam logic [CNT_W-1:0] PERIOD = CNT_W'(1) << DUTY_W;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOW_T  = CNT_W'(LOW_TIMEOUT);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    IDLE_LOW
  } state_t;

  state_t            state;
  logic              s1;
  logic              s2;
  logic              s3;
  logic [CNT_W-1:0]  pcnt;
  logic [CNT_W-1:0]  hcnt;
  logic [DUTY_W-1:0] duty_r;
  logic              duty_valid_r;
  logic              locked_r;
  logic              period_err_r;
  logic              rise;

  // A frame that stayed high for all P cycles would wrap the duty field to 0;
  // clamp to the largest legal duty instead.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [CNT_W-1:0] h);
    if (h >= PERIOD) begin
      return {DUTY_W{1'b1}};
    end
    return h[DUTY_W-1:0];
  endfunction

  assign rise = s2 & ~s3;

  always_ff @(posedge clk_out) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= SEARCH;
      pcnt         <= '0;
      hcnt         <= '0;
      duty_r       <= '0;
      duty_valid_r <= 1'b0;
      locked_r     <= 1'b0;
      period_err_r <= 1'b0;
    end else begin
      // synchronizer stage and edge history
      s1           <= bus.pwm_in;
      s2           <= s1;
      s3           <= s2;
      duty_valid_r <= 1'b0;
      period_err_r <= 1'b0;

      // frame tracking stage
      case (state)
        SEARCH: begin
          if (rise) begin
            pcnt  <= ONE;
            hcnt  <= ONE;
            state <= MEASURE;
          end else if (s2) begin
            pcnt <= '0;
          end else if (pcnt == LOW_T) begin
            duty_r       <= '0;
            duty_valid_r <= 1'b1;
            locked_r     <= 1'b1;
            pcnt         <= ONE;
            state        <= IDLE_LOW;
          end else begin
            pcnt <= pcnt + ONE;
          end
        end

        MEASURE: begin
          if (rise) begin
            if (pcnt == PERIOD) begin
              duty_r       <= sat_duty(hcnt);
              duty_valid_r <= 1'b1;
              locked_r     <= 1'b1;
            end else begin
              period_err_r <= 1'b1;
              locked_r     <= 1'b0;
            end
            pcnt <= ONE;
            hcnt <= ONE;
          end else if (pcnt < PERIOD) begin
            pcnt <= pcnt + ONE;
            hcnt <= hcnt + {{DUTY_W{1'b0}}, s2};
          end else if (!s2) begin
            // frame closed and the line went quiet: report it, then watch for duty 0
            duty_r       <= sat_duty(hcnt);
            duty_valid_r <= 1'b1;
            pcnt         <= ONE;
            state        <= IDLE_LOW;
          end else begin
            period_err_r <= 1'b1;
            locked_r     <= 1'b0;
            pcnt         <= '0;
            state        <= SEARCH;
          end
        end

        IDLE_LOW: begin
          if (pcnt < PERIOD) begin
            if (rise) begin
              period_err_r <= 1'b1;
              locked_r     <= 1'b0;
              pcnt         <= ONE;
              hcnt         <= ONE;
              state        <= MEASURE;
            end else begin
              pcnt <= pcnt + ONE;
            end
          end else begin
            duty_r       <= '0;
            duty_valid_r <= 1'b1;
            if (rise) begin
              pcnt  <= ONE;
              hcnt  <= ONE;
              state <= MEASURE;
            end else begin
              pcnt <= ONE;
            end
          end
        end

        default: begin
          state <= SEARCH;
          pcnt  <= '0;
        end
      endcase
    end
  end

  assign bus.duty       = duty_r;
  assign bus.duty_valid = duty_valid_r;
  assign bus.locked     = locked_r;
  assign bus.period_err = period_err_r;

endmodule
